// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM encoding and decode helpers
// for the load_store_unit slice.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RD   = ST_RD,
        S_WR   = ST_WR,
        S_RESP = ST_RESP
    } state_t;

    function automatic logic f3_byte(input logic [2:0] f3);
        return f3[1:0] == F3_B[1:0];
    endfunction

    function automatic logic f3_half(input logic [2:0] f3);
        return f3[1:0] == F3_H[1:0];
    endfunction

    // 010, 011, 110, 111 all behave as word accesses
    function automatic logic f3_word(input logic [2:0] f3);
        return f3[1] == F3_W[1];
    endfunction

    function automatic logic f3_uns(input logic [2:0] f3);
        return f3[2] == F3_BU[2];
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: byte/half lane extraction with sign/zero extension,
// and sub-word merge of store data into a memory word.
module lsu_lane
    import lsu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] word,
    input  logic [1:0]   off,
    input  logic [2:0]   funct3,
    input  logic [N-1:0] wdata,
    output logic [N-1:0] load,
    output logic [N-1:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        is_b;
    logic        is_h;
    logic        sx;

    assign lane_b = word[{off, 3'b000} +: 8];
    assign lane_h = word[{off[1], 4'b0000} +: 16];
    assign is_b   = f3_byte(funct3);
    assign is_h   = f3_half(funct3);
    assign sx     = ~f3_uns(funct3);

    always_comb begin
        load   = word;
        merged = wdata;
        unique case (1'b1)
            is_b: begin
                load   = {{(N-8){sx & lane_b[7]}}, lane_b};
                merged = word;
                merged[{off, 3'b000} +: 8] = wdata[7:0];
            end
            is_h: begin
                load   = {{(N-16){sx & lane_h[15]}}, lane_h};
                merged = word;
                merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load   = word;
                merged = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I LSU in front of a word-addressed data memory.
// Sub-word stores are read-modify-write; MISALIGN_TRAP_EN enables traps.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int N  = 32,
    parameter int AW = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic         st,
    input  logic [2:0]   funct3,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] rdata,
    output logic         err,
    output logic [N-1:0] mem_a,
    output logic         mem_we,
    output logic [N-1:0] mem_wd,
    input  logic [N-1:0] mem_rd
);

    state_t       state;
    state_t       state_nxt;
    logic         st_q;
    logic [2:0]   f3_q;
    logic [1:0]   off_q;
    logic [N-1:0] wdata_q;
    logic [N-1:0] word_q;
    logic [N-1:0] mem_a_q;
    logic [N-1:0] mem_wd_q;
    logic [N-1:0] lane_word;
    logic [N-1:0] lane_load;
    logic [N-1:0] lane_merged;
    logic         accept;
    logic         mis;
    logic         trap;
    logic         unused_addr;

    assign unused_addr = ^addr[N-1:AW+2];
    assign accept      = (state == S_IDLE) && req;

`ifdef MISALIGN_TRAP_EN
    logic err_q;

    assign mis  = (f3_half(funct3) && addr[0])
                | (f3_word(funct3) && (addr[1:0] != 2'b00));
    assign trap = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else if (accept) err_q <= mis;
    end
`else
    assign mis  = 1'b0;
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (req) begin
                    if (mis) state_nxt = S_RESP;
                    else if (st && f3_word(funct3)) state_nxt = S_WR;
                    else state_nxt = S_RD;
                end
            end
            S_RD:    state_nxt = st_q ? S_WR : S_RESP;
            S_WR:    state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // mem_a is set at accept so it is stable through RD and WR
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q     <= 1'b0;
            f3_q     <= 3'b000;
            off_q    <= 2'b00;
            wdata_q  <= '0;
            word_q   <= '0;
            mem_a_q  <= '0;
            mem_wd_q <= '0;
        end else begin
            if (accept) begin
                st_q    <= st;
                f3_q    <= funct3;
                off_q   <= addr[1:0];
                wdata_q <= wdata;
                if (!mis) mem_a_q <= {{(N-AW){1'b0}}, addr[AW+1:2]};
                if (!mis && st && f3_word(funct3)) mem_wd_q <= wdata;
            end
            if (state == S_RD) begin
                word_q <= mem_rd;
                if (st_q) mem_wd_q <= lane_merged;
            end
        end
    end

    // merge uses the live read word; extraction uses the captured one
    assign lane_word = (state == S_RD) ? mem_rd : word_q;

    lsu_lane #(.N(N)) u_lane (
        .word   (lane_word),
        .off    (off_q),
        .funct3 (f3_q),
        .wdata  (wdata_q),
        .load   (lane_load),
        .merged (lane_merged)
    );

    assign busy   = (state != S_IDLE);
    assign done   = (state == S_RESP);
    assign mem_we = (state == S_WR);
    assign mem_a  = mem_a_q;
    assign mem_wd = mem_wd_q;
    assign err    = done & trap;
    assign rdata  = (done && !st_q && !trap) ? lane_load : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit
// with a behavioural word memory; honours MISALIGN_TRAP_EN.
module tb_load_store_unit;

    localparam int N  = 32;
    localparam int AW = 10;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req = 1'b0;
    logic          st = 1'b0;
    logic [2:0]    funct3 = 3'b000;
    logic [N-1:0]  addr = '0;
    logic [N-1:0]  wdata = '0;
    logic          busy;
    logic          done;
    logic [N-1:0]  rdata;
    logic          err;
    logic [N-1:0]  mem_a;
    logic          mem_we;
    logic [N-1:0]  mem_wd;
    logic [N-1:0]  mem_rd;

    logic [31:0]   mem [1<<AW];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_a = '0;
    logic [31:0]   pl_d = '0;

    int            total = 0;
    int            bad = 0;
    int            we_cnt = 0;
    logic [31:0]   we_a = '0;
    exp_t          sb[$];

    load_store_unit #(.N(N), .AW(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .st     (st),
        .funct3 (funct3),
        .addr   (addr),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .rdata  (rdata),
        .err    (err),
        .mem_a  (mem_a),
        .mem_we (mem_we),
        .mem_wd (mem_wd),
        .mem_rd (mem_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (mem_we) mem[mem_a[AW-1:0]] <= mem_wd;
    end

    assign mem_rd = mem_we ? '0 : mem[mem_a[AW-1:0]];

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            we_cnt++;
            we_a = mem_a;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input string tag, input logic s,
                          input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] w, input logic [31:0] exp_rd,
                          input logic exp_err, input int lat);
        exp_t e;
        int   n;
        st = s; funct3 = f; addr = a; wdata = w; req = 1'b1;
        sb.push_back('{exp_rd, exp_err});
        @(negedge clk);
        req = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".lat"}, n, lat);
        e = sb.pop_front();
        chk({tag, ".rdata"}, rdata, e.rd);
        chk({tag, ".err"}, 32'(err), 32'(e.err));
        @(negedge clk);
        chk({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int   w0;
        int   dn;
        exp_t e;

        pl_en = 1'b1; pl_a = 10'd7; pl_d = 32'h8081_F2F3;
        @(negedge clk);
        pl_a = 10'd10; pl_d = 32'h0;
        @(negedge clk);
        pl_en = 1'b0;
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.err", 32'(err), 0);
        chk("rst.we", 32'(mem_we), 0);
        chk("rst.rdata", rdata, 0);
        chk("rst.mem_a", mem_a, 0);
        chk("rst.mem_wd", mem_wd, 0);
        rst = 1'b1;
        @(negedge clk);

        access("lb", 0, 3'b000, 32'h1C, 0, 32'hFFFF_FFF3, 0, 2);
        access("lbu", 0, 3'b100, 32'h1F, 0, 32'h0000_0080, 0, 2);
        access("lh", 0, 3'b001, 32'h1E, 0, 32'hFFFF_8081, 0, 2);
        access("lhu", 0, 3'b101, 32'h1C, 0, 32'h0000_F2F3, 0, 2);
        access("lw", 0, 3'b010, 32'h1C, 0, 32'h8081_F2F3, 0, 2);
        access("lw_wrap", 0, 3'b010, 32'h8000_001C, 0, 32'h8081_F2F3, 0, 2);
        chk("wrap.mem_a", mem_a, 32'd7);

        w0 = we_cnt;
        access("sw", 1, 3'b010, 32'h28, 32'h1234_5678, 0, 0, 2);
        chk("sw.we_cnt", we_cnt - w0, 1);
        chk("sw.we_a", we_a, 32'd10);
        chk("sw.mem", mem[10], 32'h1234_5678);

        w0 = we_cnt;
        access("sb", 1, 3'b000, 32'h29, 32'hFFFF_FFAB, 0, 0, 3);
        chk("sb.we_cnt", we_cnt - w0, 1);
        chk("sb.mem", mem[10], 32'h1234_AB78);

        // SH with a second request pulsed while busy
        st = 1'b1; funct3 = 3'b001; addr = 32'h2A; wdata = 32'h5555_BEEF;
        req = 1'b1;
        sb.push_back('{32'h0, 1'b0});
        @(negedge clk);
        st = 1'b0; funct3 = 3'b010; addr = 32'h1C;
        @(negedge clk);
        req = 1'b0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) begin
                dn++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sh.rdata", rdata, e.rd);
                end
            end
            @(negedge clk);
        end
        chk("sh.dones", dn, 1);
        chk("sh.mem", mem[10], 32'hBEEF_AB78);

        // held request, loads: one access per 3 cycles
        st = 1'b0; funct3 = 3'b010; addr = 32'h1C; req = 1'b1;
        dn = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dn++;
                chk("held_lw.rdata", rdata, 32'h8081_F2F3);
            end
        end
        req = 1'b0;
        chk("held_lw.dones", dn, 3);
        @(negedge clk);
        chk("held_lw.idle", 32'(busy), 0);

        // held request, byte stores: one access per 4 cycles
        st = 1'b1; funct3 = 3'b000; addr = 32'h28; wdata = 32'h11; req = 1'b1;
        w0 = we_cnt;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        req = 1'b0;
        chk("held_sb.dones", dn, 2);
        chk("held_sb.we_cnt", we_cnt - w0, 2);
        @(negedge clk);
        chk("held_sb.mem", mem[10], 32'hBEEF_AB11);
        chk("held_sb.idle", 32'(busy), 0);

        // async reset in the WR cycle of an SB
        st = 1'b1; funct3 = 3'b000; addr = 32'h2B; wdata = 32'h55; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("rwr.we_before", 32'(mem_we), 1);
        #1 rst = 1'b0;
        #1;
        chk("rwr.we", 32'(mem_we), 0);
        chk("rwr.busy", 32'(busy), 0);
        chk("rwr.done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b1;
        chk("rwr.mem", mem[10], 32'hBEEF_AB11);
        @(negedge clk);
        chk("rwr.idle", 32'(busy), 0);

        w0 = we_cnt;
`ifdef MISALIGN_TRAP_EN
        access("lw_mis", 0, 3'b010, 32'h2A, 0, 32'h0, 1, 1);
        access("sw_mis", 1, 3'b010, 32'h29, 32'hDEAD_BEEF, 32'h0, 1, 1);
        chk("mis.we_cnt", we_cnt - w0, 0);
        chk("mis.mem", mem[10], 32'hBEEF_AB11);
`else
        access("lw_mis", 0, 3'b010, 32'h2A, 0, 32'hBEEF_AB11, 0, 2);
        access("lh_odd", 0, 3'b001, 32'h1D, 0, 32'hFFFF_F2F3, 0, 2);
        chk("mis.we_cnt", we_cnt - w0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
